mips_bus_arbiter: RTL and testbench

//  Shares the CPU's single Avalon master port between two requesters: instruction fetch (IF) and load/store (D).

---
 rtl/mips_bus_pkg.sv | 11 +
 rtl/mips_bus_if.sv | 40 ++++
 rtl/mips_bus_watchdog.sv | 42 ++++
 rtl/mips_bus_arbiter.sv | 125 ++++++++++++
 tb/tb_mips_bus_arbiter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the two-requester MIPS Avalon bus arbiter.
package mips_bus_pkg;

    typedef enum logic [1:0] {IDLE, BUS, RESP} arb_state_t;
    typedef enum logic {OWN_IF, OWN_D} owner_t;

    localparam int unsigned POLICY_FIXED = 0;
    localparam int unsigned POLICY_RR    = 1;
    localparam logic [3:0]  BE_WORD      = 4'b1111;

endpackage

// File: rtl/mips_bus_if.sv
// Requester-side and Avalon-side signals of the bus arbiter bundled together.
interface mips_bus_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] d_rdata;
    logic        d_done;

    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    logic        busy;
    logic        bus_timeout;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, waitrequest, readdata,
        output if_rdata, if_done, d_rdata, d_done, address, read, write, writedata,
               byteenable, busy, bus_timeout
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, waitrequest, readdata,
        input  if_rdata, if_done, d_rdata, d_done, address, read, write, writedata,
               byteenable, busy, bus_timeout
    );

endinterface

// File: rtl/mips_bus_watchdog.sv
// Counts stalled bus cycles and flags an abort once TIMEOUT_CYCLES is reached.
module mips_bus_watchdog
    import mips_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 11
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic expired,
    output logic timeout_flag
);

    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit               ENABLED = (TIMEOUT_CYCLES != 0);

    logic [CNT_W-1:0] r_cnt;
    logic             r_flag;

    // Fires on the stall cycle that brings the count up to TIMEOUT_CYCLES.
    assign expired      = ENABLED && en && (r_cnt == LAST);
    assign timeout_flag = r_flag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_flag <= 1'b0;
        end else begin
            if (clr) begin
                r_cnt <= '0;
            end else if (en) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (expired) begin
                r_flag <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Serialises IF and load/store transfers onto a single Avalon master port.
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int unsigned POLICY         = POLICY_FIXED,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 11
) (
    input  logic       clk,
    input  logic       reset,
    mips_bus_if.master bus
);

    localparam bit RR = (POLICY == POLICY_RR);

    arb_state_t  r_state, w_state_nxt;
    owner_t      r_owner, r_last, w_grant;
    logic        w_start, w_end, w_ack, w_expired, w_timeout, w_wd_en, w_wd_clr, w_resp;
    logic        r_read, r_write;
    logic [31:0] r_address, r_writedata, r_rdata;
    logic [3:0]  r_byteenable;

    assign w_ack    = !bus.waitrequest;
    assign w_wd_en  = (r_state == BUS) && bus.waitrequest;
    assign w_wd_clr = (r_state != BUS);

    // A tie goes to D unless round-robin and D was the last one served.
    always_comb begin
        w_grant = OWN_IF;
        if (bus.d_req && (!bus.if_req || !RR || r_last == OWN_IF)) begin
            w_grant = OWN_D;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_end       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    w_start     = 1'b1;
                    w_state_nxt = BUS;
                end
            end
            BUS: begin
                if (w_ack || w_expired) begin
                    w_end       = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner      <= OWN_IF;
            r_last       <= OWN_IF;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_address    <= '0;
            r_writedata  <= '0;
            r_byteenable <= '0;
            r_rdata      <= '0;
        end else if (w_start) begin
            r_owner <= w_grant;
            r_last  <= w_grant;
            r_rdata <= '0;
            if (w_grant == OWN_D) begin
                r_address    <= bus.d_addr;
                r_read       <= !bus.d_we;
                r_write      <= bus.d_we;
                r_writedata  <= bus.d_wdata;
                r_byteenable <= bus.d_be;
            end else begin
                r_address    <= bus.if_addr;
                r_read       <= 1'b1;
                r_write      <= 1'b0;
                r_writedata  <= '0;
                r_byteenable <= BE_WORD;
            end
        end else if (w_end) begin
            // Writes and watchdog aborts hand back zero instead of bus data.
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_rdata <= (w_ack && r_read) ? bus.readdata : '0;
        end
    end

    mips_bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_watchdog (
        .clk         (clk),
        .reset       (reset),
        .en          (w_wd_en),
        .clr         (w_wd_clr),
        .expired     (w_expired),
        .timeout_flag(w_timeout)
    );

    assign w_resp          = (r_state == RESP);
    assign bus.if_done     = w_resp && (r_owner == OWN_IF);
    assign bus.d_done      = w_resp && (r_owner == OWN_D);
    assign bus.if_rdata    = bus.if_done ? r_rdata : '0;
    assign bus.d_rdata     = bus.d_done ? r_rdata : '0;
    assign bus.address     = r_address;
    assign bus.read        = r_read;
    assign bus.write       = r_write;
    assign bus.writedata   = r_writedata;
    assign bus.byteenable  = r_byteenable;
    assign bus.busy        = (r_state != IDLE);
    assign bus.bus_timeout = w_timeout;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter: a fixed-priority/watchdog instance and a round-robin instance share stimulus.
module tb_mips_bus_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mips_bus_if bus_f ();
    mips_bus_if bus_r ();

    mips_bus_arbiter #(.POLICY(0), .TIMEOUT_CYCLES(8), .CNT_W(4)) u_fix (
        .clk(clk), .reset(reset), .bus(bus_f)
    );
    mips_bus_arbiter #(.POLICY(1), .TIMEOUT_CYCLES(0), .CNT_W(4)) u_rr (
        .clk(clk), .reset(reset), .bus(bus_r)
    );

    assign bus_r.if_req      = bus_f.if_req;
    assign bus_r.if_addr     = bus_f.if_addr;
    assign bus_r.d_req       = bus_f.d_req;
    assign bus_r.d_we        = bus_f.d_we;
    assign bus_r.d_addr      = bus_f.d_addr;
    assign bus_r.d_wdata     = bus_f.d_wdata;
    assign bus_r.d_be        = bus_f.d_be;
    assign bus_r.waitrequest = bus_f.waitrequest;
    assign bus_r.readdata    = bus_f.readdata;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] bus_rdata;
        int          waits;
        logic        exp_read;
        logic        exp_write;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];
    vec_t v_after;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus_f.if_req      = 1'b0;
        bus_f.if_addr     = '0;
        bus_f.d_req       = 1'b0;
        bus_f.d_we        = 1'b0;
        bus_f.d_addr      = '0;
        bus_f.d_wdata     = '0;
        bus_f.d_be        = '0;
        bus_f.waitrequest = 1'b0;
        bus_f.readdata    = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One transfer on an idle arbiter; starts at a falling edge, inputs for cycle c set at its falling edge.
    task automatic run_xfer(input vec_t v, input string nm);
        @(negedge clk);
        bus_f.if_req      = !v.is_d;
        bus_f.d_req       = v.is_d;
        bus_f.if_addr     = v.is_d ? 32'hBAD0_0000 : v.addr;
        bus_f.d_addr      = v.is_d ? v.addr : 32'hBAD0_0004;
        bus_f.d_we        = v.we;
        bus_f.d_wdata     = v.wdata;
        bus_f.d_be        = v.be;
        bus_f.waitrequest = 1'b1;
        bus_f.readdata    = 32'hEEEE_EEEE;
        for (int c = 1; c <= v.waits + 1; c++) begin
            @(negedge clk);
            chk({nm, ".read"},  bus_f.read,       v.exp_read);
            chk({nm, ".write"}, bus_f.write,      v.exp_write);
            chk({nm, ".addr"},  bus_f.address,    v.addr);
            chk({nm, ".be"},    bus_f.byteenable, v.exp_be);
            chk({nm, ".wdata"}, bus_f.writedata,  v.exp_wdata);
            chk({nm, ".busy"},  bus_f.busy,       1'b1);
            chk({nm, ".early_done"}, {bus_f.if_done, bus_f.d_done}, 2'b00);
            bus_f.waitrequest = (c <= v.waits);
            bus_f.readdata    = (c <= v.waits) ? 32'hEEEE_EEEE : v.bus_rdata;
        end
        @(negedge clk);
        chk({nm, ".done"}, {bus_f.if_done, bus_f.d_done}, v.is_d ? 2'b01 : 2'b10);
        chk({nm, ".rdata"}, v.is_d ? bus_f.d_rdata : bus_f.if_rdata, v.exp_rdata);
        chk({nm, ".other_rdata"}, v.is_d ? bus_f.if_rdata : bus_f.d_rdata, 32'h0);
        chk({nm, ".strobes_off"}, {bus_f.read, bus_f.write}, 2'b00);
        bus_f.if_req      = 1'b0;
        bus_f.d_req       = 1'b0;
        bus_f.waitrequest = 1'b0;
        @(negedge clk);
        chk({nm, ".idle"}, {bus_f.busy, bus_f.if_done, bus_f.d_done}, 3'b000);
    endtask

    initial begin
        #100000;
        $display("FAIL tb_timeout: bench did not complete in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h0040_0000, 32'h0000_0000, 4'h0,    32'h2402_000A, 0,
                    1'b1, 1'b0, 4'hF,    32'h0000_0000, 32'h2402_000A};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_1000, 32'hCAFE_F00D, 4'b0011, 32'hDEAD_BEEF, 3,
                    1'b0, 1'b1, 4'b0011, 32'hCAFE_F00D, 32'h0000_0000};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_2004, 32'h55AA_55AA, 4'hF,    32'h1234_5678, 1,
                    1'b1, 1'b0, 4'hF,    32'h55AA_55AA, 32'h1234_5678};
        vecs[3] = '{1'b0, 1'b1, 32'h0040_0004, 32'h1111_1111, 4'h3,    32'h8C43_0000, 2,
                    1'b1, 1'b0, 4'hF,    32'h0000_0000, 32'h8C43_0000};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_3000, 32'h0000_0000, 4'b0100, 32'hA5A5_A5A5, 0,
                    1'b1, 1'b0, 4'b0100, 32'h0000_0000, 32'hA5A5_A5A5};
        v_after = '{1'b0, 1'b0, 32'h0040_0008, 32'h0000_0000, 4'h0,    32'h0800_0010, 1,
                    1'b1, 1'b0, 4'hF,    32'h0000_0000, 32'h0800_0010};

        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        chk("rst.strobes", {bus_f.read, bus_f.write, bus_f.busy, bus_f.bus_timeout}, 4'b0000);
        chk("rst.done",    {bus_f.if_done, bus_f.d_done, bus_r.if_done, bus_r.d_done}, 4'b0000);
        chk("rst.address", bus_f.address,    32'h0);
        chk("rst.wdata",   bus_f.writedata,  32'h0);
        chk("rst.be",      bus_f.byteenable, 4'h0);
        chk("rst.rdata",   bus_f.if_rdata | bus_f.d_rdata, 32'h0);
        chk("rst.rr_busy", bus_r.busy, 1'b0);
        reset = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_xfer(vecs[i], $sformatf("vec%0d", i));
        end

        // Both requesters held: fixed priority starves IF, round-robin alternates.
        do_reset();
        @(negedge clk);
        bus_f.if_req   = 1'b1;
        bus_f.if_addr  = 32'h0040_0200;
        bus_f.d_req    = 1'b1;
        bus_f.d_we     = 1'b0;
        bus_f.d_addr   = 32'h0000_2000;
        bus_f.d_be     = 4'hF;
        bus_f.readdata = 32'h0BAD_F00D;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            chk($sformatf("tie.fix_d_done.c%0d", c),  bus_f.d_done,  ((c % 3) == 2) && (c <= 11));
            chk($sformatf("tie.fix_if_done.c%0d", c), bus_f.if_done, c == 14);
            chk($sformatf("tie.rr_d_done.c%0d", c),   bus_r.d_done,  (c == 2) || (c == 8));
            chk($sformatf("tie.rr_if_done.c%0d", c),  bus_r.if_done, (c == 5) || (c == 11) || (c == 14));
            if (c == 11) bus_f.d_req = 1'b0;
            if (c == 14) bus_f.if_req = 1'b0;
        end

        // Payload changes mid-stall must not reach the bus.
        @(negedge clk);
        bus_f.d_req       = 1'b1;
        bus_f.d_we        = 1'b0;
        bus_f.d_addr      = 32'h0000_0010;
        bus_f.d_be        = 4'hF;
        bus_f.waitrequest = 1'b1;
        bus_f.readdata    = 32'h600D_0010;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("latch.addr.c%0d", c), bus_f.address, 32'h0000_0010);
            if (c == 2) bus_f.d_addr = 32'h0000_0020;
            if (c == 4) bus_f.waitrequest = 1'b0;
        end
        @(negedge clk);
        chk("latch.done",  bus_f.d_done,  1'b1);
        chk("latch.addr",  bus_f.address, 32'h0000_0010);
        chk("latch.rdata", bus_f.d_rdata, 32'h600D_0010);
        bus_f.d_req = 1'b0;
        @(negedge clk);

        // Watchdog abort after 8 stalled cycles on the fixed instance.
        @(negedge clk);
        bus_f.d_req       = 1'b1;
        bus_f.d_we        = 1'b0;
        bus_f.d_addr      = 32'h0000_0030;
        bus_f.d_be        = 4'hF;
        bus_f.waitrequest = 1'b1;
        bus_f.readdata    = 32'hFFFF_FFFF;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk($sformatf("wd.read.c%0d", c), bus_f.read, 1'b1);
            chk($sformatf("wd.flag.c%0d", c), bus_f.bus_timeout, 1'b0);
            chk($sformatf("wd.done.c%0d", c), bus_f.d_done, 1'b0);
        end
        @(negedge clk);
        chk("wd.strobe_drop", bus_f.read,        1'b0);
        chk("wd.done",        bus_f.d_done,      1'b1);
        chk("wd.rdata",       bus_f.d_rdata,     32'h0);
        chk("wd.flag_set",    bus_f.bus_timeout, 1'b1);
        chk("wd.rr_stalled",  bus_r.read,        1'b1);
        bus_f.d_req = 1'b0;
        @(negedge clk);
        chk("wd.idle",        bus_f.busy,        1'b0);
        chk("wd.flag_sticky", bus_f.bus_timeout, 1'b1);
        bus_f.waitrequest = 1'b0;
        repeat (4) @(negedge clk);
        run_xfer(v_after, "after_wd");
        chk("after_wd.flag", bus_f.bus_timeout, 1'b1);

        // Asynchronous reset in the middle of a stalled read.
        @(negedge clk);
        bus_f.if_req      = 1'b1;
        bus_f.if_addr     = 32'h0040_0100;
        bus_f.waitrequest = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("arst.pre_read", bus_f.read, 1'b1);
        chk("arst.pre_busy", bus_f.busy, 1'b1);
        #2;
        reset        = 1'b0;
        bus_f.if_req = 1'b0;
        #1;
        chk("arst.read",  bus_f.read,  1'b0);
        chk("arst.write", bus_f.write, 1'b0);
        chk("arst.busy",  {bus_f.busy, bus_r.busy}, 2'b00);
        chk("arst.done",  {bus_f.if_done, bus_f.d_done}, 2'b00);
        chk("arst.flag",  bus_f.bus_timeout, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset             = 1'b1;
        bus_f.waitrequest = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk($sformatf("arst.after.c%0d", c),
                {bus_f.busy, bus_f.if_done, bus_f.d_done, bus_f.read}, 4'b0000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
